// File: rtl/aes_enc_iter.sv
// Iterative AES encryption core: one full round per clock over a 128-bit state,
// with round keys fetched combinationally from an external key schedule by round index.

module aes_mixcol (
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  assign {w_a0, w_a1, w_a2, w_a3} = i_col;

  assign o_col = {xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
                  w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3,
                  w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3,
                  xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3)};
endmodule

module aes_enc_iter #(
  parameter int NR     = 10,
  parameter int RIDX_W = 4
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [127:0]      plain_text_i,
  input  logic [127:0]      key_i,
  input  logic [127:0]      rnd_key_i,
  output logic [RIDX_W-1:0] rnd_idx_o,
  input  logic              abort_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [127:0]      cipher_o,
  output logic              busy_o
);
  localparam int NB        = 16;
  localparam int NUM_LANES = 4;
  localparam logic [RIDX_W-1:0] LAST_RC = RIDX_W'(NR);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_enc_iter: NR must be 10, 12 or 14");
  end
  if ((1 << RIDX_W) <= NR) begin : g_bad_ridx
    $error("aes_enc_iter: RIDX_W too narrow for NR");
  end

  // Byte 0 of the table sits in the top bits, so byte b lives at bit offset 8*(255-b).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t              r_state;
  logic [127:0]        r_st;
  logic [127:0]        r_cipher;
  logic [RIDX_W-1:0]   r_rc;
  logic                r_out_valid;

  logic [0:NB-1][7:0]  w_st_b;
  logic [0:NB-1][7:0]  w_sr_b;
  logic [127:0]        w_t;
  logic [127:0]        w_mc;
  logic [127:0]        w_rnd;

  assign w_st_b = r_st;

  // State is column-major: byte i is row i%4 of column i/4; ShiftRows rotates row r left by r.
  for (genvar g = 0; g < NB; g++) begin : g_sbsr
    assign w_sr_b[g] = sbox(w_st_b[4 * (((g / 4) + (g % 4)) % 4) + (g % 4)]);
  end
  assign w_t = w_sr_b;

  aes_mixcol u_mc [NUM_LANES-1:0] (
    .i_col (w_t),
    .o_col (w_mc)
  );

  assign w_rnd = ((r_rc == LAST_RC) ? w_t : w_mc) ^ rnd_key_i;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= IDLE;
      r_st        <= '0;
      r_rc        <= '0;
      r_cipher    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_st    <= plain_text_i ^ key_i;
            r_rc    <= RIDX_W'(1);
            r_state <= ROUND;
          end
        end
        ROUND: begin
          if (abort_i) begin
            r_state     <= IDLE;
            r_st        <= '0;
            r_rc        <= '0;
            r_out_valid <= 1'b0;
          end else begin
            r_st <= w_rnd;
            r_rc <= r_rc + 1'b1;
            if (r_rc == LAST_RC) begin
              r_state     <= DONE;
              r_cipher    <= w_rnd;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort_i) begin
            r_state     <= IDLE;
            r_st        <= '0;
            r_rc        <= '0;
            r_out_valid <= 1'b0;
          end else if (out_ready_i) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign rnd_idx_o   = (r_state == ROUND) ? r_rc : '0;
  assign out_valid_o = r_out_valid;
  assign cipher_o    = r_cipher;
endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench for aes_enc_iter: FIPS-197 vectors on NR=10 and NR=14 instances with
// a bench-side key schedule, plus backpressure, back-to-back, abort and mid-block reset.

module tb_aes_enc_iter;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic iv10, ir10, ab10, ov10, or10, bz10;
  logic [127:0] pt10, k10, rk10, c10;
  logic [3:0] idx10;
  logic iv14, ir14, ab14, ov14, or14, bz14;
  logic [127:0] pt14, k14, rk14, c14;
  logic [3:0] idx14;

  logic [127:0] ks10 [0:15];
  logic [127:0] ks14 [0:15];
  logic [7:0]   bsbox [0:255];
  logic [31:0]  w [0:59];

  assign rk10 = ks10[idx10];
  assign rk14 = ks14[idx14];

  int n_cmp = 0;
  int n_bad = 0;

  aes_enc_iter #(.NR(10), .RIDX_W(4)) u10 (
    .clk(clk), .nrst(nrst), .in_valid_i(iv10), .in_ready_o(ir10), .plain_text_i(pt10),
    .key_i(k10), .rnd_key_i(rk10), .rnd_idx_o(idx10), .abort_i(ab10), .out_valid_o(ov10),
    .out_ready_i(or10), .cipher_o(c10), .busy_o(bz10));

  aes_enc_iter #(.NR(14), .RIDX_W(4)) u14 (
    .clk(clk), .nrst(nrst), .in_valid_i(iv14), .in_ready_o(ir14), .plain_text_i(pt14),
    .key_i(k14), .rnd_key_i(rk14), .rnd_idx_o(idx14), .abort_i(ab14), .out_valid_o(ov14),
    .out_ready_i(or14), .cipher_o(c14), .busy_o(bz14));

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse and affine map rather than a table.
  task automatic build_sbox();
    logic [7:0] r, x;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      r = 8'h01;
      for (int e = 0; e < 254; e++) r = gmul(r, x);
      bsbox[v] = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {bsbox[t[31:24]], bsbox[t[23:16]], bsbox[t[15:8]], bsbox[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 60; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  task automatic set_ks10(input logic [127:0] k);
    expand({k, 128'h0}, 4);
    for (int i = 0; i < 15; i++) ks10[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  endtask

  task automatic set_ks14(input logic [255:0] k);
    expand(k, 8);
    for (int i = 0; i < 15; i++) ks14[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
  endtask

  // Accepts one block from IDLE and waits (bounded) for out_valid; records what it saw.
  task automatic run10(input logic [127:0] p, input logic [127:0] k,
                       output logic [127:0] c, output int lat, output int idx_bad);
    set_ks10(k);
    pt10 = p; k10 = k; iv10 = 1'b1;
    @(posedge clk); #1;
    iv10 = 1'b0; pt10 = ~p; k10 = ~k;
    lat = 0; idx_bad = 0;
    while (!ov10 && lat < 40) begin
      if (int'(idx10) != lat + 1) idx_bad++;
      @(posedge clk); #1;
      lat++;
    end
    c = c10;
  endtask

  task automatic run14(input logic [127:0] p, input logic [255:0] k,
                       output logic [127:0] c, output int lat, output int idx_bad);
    set_ks14(k);
    pt14 = p; k14 = k[255:128]; iv14 = 1'b1;
    @(posedge clk); #1;
    iv14 = 1'b0; pt14 = ~p; k14 = ~k[255:128];
    lat = 0; idx_bad = 0;
    while (!ov14 && lat < 40) begin
      if (int'(idx14) != lat + 1) idx_bad++;
      @(posedge clk); #1;
      lat++;
    end
    c = c14;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (ir10 !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", ir10); end
    n_cmp++; if (bz10 !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bz10); end
    n_cmp++; if (ov10 !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", ov10); end
    n_cmp++; if (c10 !== 128'h0) begin n_bad++; $display("FAIL rst_cipher: got %h want 0", c10); end
    n_cmp++; if (idx10 !== 4'd0) begin n_bad++; $display("FAIL rst_idx: got %0d want 0", idx10); end
    n_cmp++; if (ir14 !== 1'b1 || ov14 !== 1'b0) begin n_bad++; $display("FAIL rst_u14: got ready %b valid %b want 1 0", ir14, ov14); end
    nrst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (ir10 !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", ir10); end
  endtask

  task automatic test_c1();
    logic [127:0] c; int lat, bad;
    run10(P1, K1, c, lat, bad);
    n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL c1_latency: got %0d want 10", lat); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL c1_idx_steps: got %0d bad want 0", bad); end
    n_cmp++; if (c !== C1) begin n_bad++; $display("FAIL c1_cipher: got %h want %h", c, C1); end
    n_cmp++; if (bz10 !== 1'b1 || ir10 !== 1'b0 || idx10 !== 4'd0) begin n_bad++; $display("FAIL c1_done_flags: got busy %b ready %b idx %0d want 1 0 0", bz10, ir10, idx10); end
    or10 = 1'b1;
    @(posedge clk); #1;
    or10 = 1'b0;
    n_cmp++; if (ir10 !== 1'b1 || ov10 !== 1'b0 || bz10 !== 1'b0) begin n_bad++; $display("FAIL c1_handshake: got ready %b valid %b busy %b want 1 0 0", ir10, ov10, bz10); end
    n_cmp++; if (c10 !== C1) begin n_bad++; $display("FAIL c1_cipher_hold: got %h want %h", c10, C1); end
  endtask

  task automatic test_c3();
    logic [127:0] c; int lat, bad;
    run14(P1, K3, c, lat, bad);
    n_cmp++; if (lat != 14) begin n_bad++; $display("FAIL c3_latency: got %0d want 14", lat); end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL c3_idx_steps: got %0d bad want 0", bad); end
    n_cmp++; if (c !== C3) begin n_bad++; $display("FAIL c3_cipher: got %h want %h", c, C3); end
    or14 = 1'b1;
    @(posedge clk); #1;
    or14 = 1'b0;
    n_cmp++; if (ir14 !== 1'b1 || ov14 !== 1'b0) begin n_bad++; $display("FAIL c3_handshake: got ready %b valid %b want 1 0", ir14, ov14); end
  endtask

  task automatic test_backpressure();
    logic [127:0] c; int lat, bad, hold_bad;
    run10(PB, KB, c, lat, bad);
    n_cmp++; if (c !== CB) begin n_bad++; $display("FAIL bp_cipher: got %h want %h", c, CB); end
    iv10 = 1'b1; pt10 = P1; k10 = K1;
    hold_bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ov10 !== 1'b1 || c10 !== CB || ir10 !== 1'b0) hold_bad++;
    end
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", hold_bad); end
    iv10 = 1'b0; or10 = 1'b1;
    @(posedge clk); #1;
    or10 = 1'b0;
    n_cmp++; if (ir10 !== 1'b1 || ov10 !== 1'b0) begin n_bad++; $display("FAIL bp_release: got ready %b valid %b want 1 0", ir10, ov10); end
  endtask

  task automatic test_back_to_back();
    set_ks10(K1);
    pt10 = P1; k10 = K1; iv10 = 1'b1; or10 = 1'b1;
    @(posedge clk); #1;
    pt10 = PB; k10 = KB;
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (ov10 !== 1'b1 || c10 !== C1) begin n_bad++; $display("FAIL b2b_first: got valid %b cipher %h want 1 %h", ov10, c10, C1); end
    n_cmp++; if (ir10 !== 1'b0) begin n_bad++; $display("FAIL b2b_not_ready_done: got %b want 0", ir10); end
    set_ks10(KB);
    @(posedge clk); #1;
    n_cmp++; if (ir10 !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: got ready %b want 1", ir10); end
    @(posedge clk); #1;
    iv10 = 1'b0;
    n_cmp++; if (bz10 !== 1'b1 || idx10 !== 4'd1) begin n_bad++; $display("FAIL b2b_second_accept: got busy %b idx %0d want 1 1", bz10, idx10); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (ov10 !== 1'b1 || c10 !== CB) begin n_bad++; $display("FAIL b2b_second: got valid %b cipher %h want 1 %h", ov10, c10, CB); end
    @(posedge clk); #1;
    or10 = 1'b0;
    n_cmp++; if (ir10 !== 1'b1 || ov10 !== 1'b0) begin n_bad++; $display("FAIL b2b_end: got ready %b valid %b want 1 0", ir10, ov10); end
  endtask

  task automatic test_abort();
    logic [127:0] c; int lat, bad, rise;
    set_ks10(K1);
    pt10 = P1; k10 = K1; iv10 = 1'b1;
    @(posedge clk); #1;
    iv10 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (idx10 !== 4'd5) begin n_bad++; $display("FAIL abort_at_rc: got %0d want 5", idx10); end
    ab10 = 1'b1; iv10 = 1'b1;
    @(posedge clk); #1;
    ab10 = 1'b0; iv10 = 1'b0;
    n_cmp++; if (ir10 !== 1'b1 || bz10 !== 1'b0 || ov10 !== 1'b0 || idx10 !== 4'd0) begin n_bad++; $display("FAIL abort_round: got ready %b busy %b valid %b idx %0d want 1 0 0 0", ir10, bz10, ov10, idx10); end
    rise = 0;
    repeat (12) begin @(posedge clk); #1; if (ov10 !== 1'b0) rise++; end
    n_cmp++; if (rise != 0) begin n_bad++; $display("FAIL abort_no_output: got %0d valid cycles want 0", rise); end
    run10(PB, KB, c, lat, bad);
    n_cmp++; if (c !== CB || lat != 10) begin n_bad++; $display("FAIL abort_next_block: got %h lat %0d want %h lat 10", c, lat, CB); end
    ab10 = 1'b1; or10 = 1'b1;
    @(posedge clk); #1;
    ab10 = 1'b0; or10 = 1'b0;
    n_cmp++; if (ir10 !== 1'b1 || ov10 !== 1'b0) begin n_bad++; $display("FAIL abort_done: got ready %b valid %b want 1 0", ir10, ov10); end
    ab10 = 1'b1; iv10 = 1'b1;
    @(posedge clk); #1;
    iv10 = 1'b0;
    n_cmp++; if (bz10 !== 1'b1 || idx10 !== 4'd1) begin n_bad++; $display("FAIL abort_idle_ignored: got busy %b idx %0d want 1 1", bz10, idx10); end
    @(posedge clk); #1;
    ab10 = 1'b0;
    n_cmp++; if (ir10 !== 1'b1 || bz10 !== 1'b0) begin n_bad++; $display("FAIL abort_cleanup: got ready %b busy %b want 1 0", ir10, bz10); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] c; int lat, bad;
    set_ks10(K1);
    pt10 = P1; k10 = K1; iv10 = 1'b1;
    @(posedge clk); #1;
    iv10 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (idx10 !== 4'd7) begin n_bad++; $display("FAIL rmid_at_rc: got %0d want 7", idx10); end
    nrst = 1'b0;
    #1;
    n_cmp++; if (ir10 !== 1'b1 || bz10 !== 1'b0 || ov10 !== 1'b0 || idx10 !== 4'd0) begin n_bad++; $display("FAIL rmid_flags: got ready %b busy %b valid %b idx %0d want 1 0 0 0", ir10, bz10, ov10, idx10); end
    n_cmp++; if (c10 !== 128'h0) begin n_bad++; $display("FAIL rmid_cipher: got %h want 0", c10); end
    #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    run10(P1, K1, c, lat, bad);
    n_cmp++; if (c !== C1 || lat != 10 || bad != 0) begin n_bad++; $display("FAIL rmid_c1: got %h lat %0d idxbad %0d want %h lat 10 idxbad 0", c, lat, bad, C1); end
    or10 = 1'b1;
    @(posedge clk); #1;
    or10 = 1'b0;
  endtask

  initial begin
    iv10 = 0; ab10 = 0; or10 = 0; pt10 = '0; k10 = '0;
    iv14 = 0; ab14 = 0; or14 = 0; pt14 = '0; k14 = '0;
    for (int i = 0; i < 16; i++) begin ks10[i] = '0; ks14[i] = '0; end
    build_sbox();
    test_reset();
    test_c1();
    test_c3();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
